// File: rtl/abc_seq_if.sv
// abc_seq_if: operand/result bundle for the multi-cycle adder/subtractor.
//   in_valid/in_ready     operand handshake (A, B, sub)
//   out_valid/out_ready   result handshake (S, Co, V, Z, N)
// The slave modport is the block itself; master is its producer/consumer.
interface abc_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Co;
  logic             V;
  logic             Z;
  logic             N;

  modport master (
    output in_valid, A, B, sub, out_ready,
    input  in_ready, out_valid, S, Co, V, Z, N
  );

  modport slave (
    input  in_valid, A, B, sub, out_ready,
    output in_ready, out_valid, S, Co, V, Z, N
  );
endinterface

// File: rtl/abc_seq.sv
// abc_seq: multi-cycle adder/subtractor, one CHUNK-bit slice per clock.
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   abc_seq_if.slave: in_valid/in_ready + A, B, sub in;
//         out_valid/out_ready + S, Co, V, Z, N out (held until consumed)
// Subtraction is A + ~B + 1; Co = 1 means no borrow.
// Optional build macro ABC_FLAGS_EN: when defined, V/Z/N are computed and
// registered on entry to DONE; otherwise they are constant 0.
module abc_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input logic       clk,
  input logic       rst,
  abc_seq_if.slave  bus
);

  localparam int unsigned NSLICE = WIDTH / CHUNK;
  localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned MSB    = WIDTH - 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] bx_q, bx_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic [CHUNK:0]   slice_sum;
  logic [CHUNK:0]   carry_ext;
  logic             in_ready;

  // rst gates in_ready combinationally so nothing is offered during reset.
  assign in_ready      = (state_q == StIdle) && !rst;
  assign carry_ext     = {{CHUNK{1'b0}}, carry_q};
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == StDone);
  assign bus.S         = s_q;
  assign bus.Co        = co_q;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    carry_d   = carry_q;
    a_d       = a_q;
    bx_d      = bx_q;
    s_d       = s_q;
    co_d      = co_q;
    slice_sum = '0;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid && in_ready) begin
          a_d     = bus.A;
          bx_d    = bus.B ^ {WIDTH{bus.sub}};
          carry_d = bus.sub;
          k_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        slice_sum = {1'b0, a_q[k_q*CHUNK +: CHUNK]} + {1'b0, bx_q[k_q*CHUNK +: CHUNK]} + carry_ext;
        s_d[k_q*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
        carry_d = slice_sum[CHUNK];
        if (k_q == KW'(NSLICE - 1)) begin
          co_d    = slice_sum[CHUNK];
          state_d = StDone;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      StDone: begin
        // No accept here even if out_ready: IDLE is always visited first.
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      bx_q    <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      bx_q    <= bx_d;
      s_q     <= s_d;
      co_q    <= co_d;
    end
  end

`ifdef ABC_FLAGS_EN
  logic v_q, z_q, n_q;
  logic done_entry;

  // Flags use the full result including the slice being written this cycle.
  assign done_entry = (state_q == StRun) && (state_d == StDone);

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
      z_q <= 1'b0;
      n_q <= 1'b0;
    end else if (done_entry) begin
      v_q <= (a_q[MSB] == bx_q[MSB]) && (s_d[MSB] != a_q[MSB]);
      z_q <= (s_d == '0);
      n_q <= s_d[MSB];
    end
  end

  assign bus.V = v_q;
  assign bus.Z = z_q;
  assign bus.N = n_q;
`else
  assign bus.V = 1'b0;
  assign bus.Z = 1'b0;
  assign bus.N = 1'b0;
`endif

endmodule

// File: tb/tb_abc_seq.sv
// Self-checking bench for abc_seq: three instances (CHUNK = 8, 32, 1) share
// operand inputs; each vector is run on each instance in turn.
module tb_abc_seq;

`ifdef ABC_FLAGS_EN
  localparam bit FlagsOn = 1'b1;
`else
  localparam bit FlagsOn = 1'b0;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] s;
    logic        co;
    logic        v;
    logic        z;
    logic        n;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  iv = 3'b000;
  logic [31:0] a_drv = '0;
  logic [31:0] b_drv = '0;
  logic        sub_drv = 1'b0;
  logic        ordy = 1'b1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  abc_seq_if #(.WIDTH(32)) bus8  ();
  abc_seq_if #(.WIDTH(32)) bus32 ();
  abc_seq_if #(.WIDTH(32)) bus1  ();

  abc_seq #(.WIDTH(32), .CHUNK(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
  abc_seq #(.WIDTH(32), .CHUNK(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));
  abc_seq #(.WIDTH(32), .CHUNK(1))  u_dut1  (.clk(clk), .rst(rst), .bus(bus1));

  assign bus8.in_valid  = iv[0];
  assign bus32.in_valid = iv[1];
  assign bus1.in_valid  = iv[2];
  assign bus8.A  = a_drv;  assign bus8.B  = b_drv;  assign bus8.sub  = sub_drv;
  assign bus32.A = a_drv;  assign bus32.B = b_drv;  assign bus32.sub = sub_drv;
  assign bus1.A  = a_drv;  assign bus1.B  = b_drv;  assign bus1.sub  = sub_drv;
  assign bus8.out_ready  = ordy;
  assign bus32.out_ready = ordy;
  assign bus1.out_ready  = ordy;

  wire        rdy_w [3];
  wire        ov_w  [3];
  wire [31:0] s_w   [3];
  wire        co_w  [3];
  wire        v_w   [3];
  wire        z_w   [3];
  wire        n_w   [3];
  assign rdy_w[0] = bus8.in_ready;  assign rdy_w[1] = bus32.in_ready; assign rdy_w[2] = bus1.in_ready;
  assign ov_w[0]  = bus8.out_valid; assign ov_w[1]  = bus32.out_valid; assign ov_w[2] = bus1.out_valid;
  assign s_w[0]   = bus8.S;         assign s_w[1]   = bus32.S;        assign s_w[2]   = bus1.S;
  assign co_w[0]  = bus8.Co;        assign co_w[1]  = bus32.Co;       assign co_w[2]  = bus1.Co;
  assign v_w[0]   = bus8.V;         assign v_w[1]   = bus32.V;        assign v_w[2]   = bus1.V;
  assign z_w[0]   = bus8.Z;         assign z_w[1]   = bus32.Z;        assign z_w[2]   = bus1.Z;
  assign n_w[0]   = bus8.N;         assign n_w[1]   = bus32.N;        assign n_w[2]   = bus1.N;

  int lat_exp [3] = '{4, 1, 32};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge after the acceptance edge; returns edges until out_valid.
  task automatic wait_done(input int sel, output int cyc);
    cyc = 0;
    while (!ov_w[sel] && cyc < 100) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic check_result(input int sel, input vec_t v, input string tag);
    check({tag, " S"},  s_w[sel],  v.s);
    check({tag, " Co"}, 32'(co_w[sel]), 32'(v.co));
    check({tag, " V"},  32'(v_w[sel]),  32'(v.v & FlagsOn));
    check({tag, " Z"},  32'(z_w[sel]),  32'(v.z & FlagsOn));
    check({tag, " N"},  32'(n_w[sel]),  32'(v.n & FlagsOn));
  endtask

  // Full transaction with out_ready already high.
  task automatic run_op(input int sel, input vec_t v, input string tag);
    int cyc;
    @(negedge clk);
    a_drv = v.a; b_drv = v.b; sub_drv = v.sub; iv[sel] = 1'b1;
    check({tag, " in_ready before accept"}, 32'(rdy_w[sel]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    iv[sel] = 1'b0;
    a_drv = ~v.a; b_drv = ~v.b; sub_drv = ~v.sub;  // latched operands must not follow
    wait_done(sel, cyc);
    check({tag, " latency"}, 32'(cyc), 32'(lat_exp[sel]));
    check({tag, " out_valid"}, 32'(ov_w[sel]), 32'd1);
    check_result(sel, v, tag);
    @(posedge clk);
    @(negedge clk);
    check({tag, " out_valid after handshake"}, 32'(ov_w[sel]), 32'd0);
    check({tag, " in_ready after handshake"}, 32'(rdy_w[sel]), 32'd1);
  endtask

  vec_t vecs [10];

  initial begin
    int   cyc;
    vec_t bp;
    vec_t two;
    vec_t post;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{32'h0000_1234, 32'h0000_1234, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{32'h0000_FF00, 32'h0000_0100, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset dut%0d in_ready", d), 32'(rdy_w[d]), 32'd0);
      check($sformatf("reset dut%0d out_valid", d), 32'(ov_w[d]), 32'd0);
      check($sformatf("reset dut%0d S", d), s_w[d], 32'd0);
      check($sformatf("reset dut%0d Co", d), 32'(co_w[d]), 32'd0);
    end
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++)
      check($sformatf("post-reset dut%0d in_ready", d), 32'(rdy_w[d]), 32'd1);

    // Table sweep over every configuration.
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 10; i++)
        run_op(d, vecs[i], $sformatf("dut%0d vec%0d", d, i));

    // Backpressure on the CHUNK=8 instance.
    bp = vecs[2];
    @(negedge clk);
    a_drv = bp.a; b_drv = bp.b; sub_drv = bp.sub; iv[0] = 1'b1; ordy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    wait_done(0, cyc);
    check("bp latency", 32'(cyc), 32'd4);
    a_drv = 32'd1; b_drv = 32'd1; sub_drv = 1'b0; iv[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp hold%0d out_valid", i), 32'(ov_w[0]), 32'd1);
      check($sformatf("bp hold%0d in_ready", i), 32'(rdy_w[0]), 32'd0);
      check_result(0, bp, $sformatf("bp hold%0d", i));
      @(posedge clk);
      @(negedge clk);
    end
    ordy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp release out_valid", 32'(ov_w[0]), 32'd0);
    check("bp release in_ready", 32'(rdy_w[0]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    check("bp new op accepted", 32'(rdy_w[0]), 32'd0);
    wait_done(0, cyc);
    two = vecs[5];
    check("bp new op latency", 32'(cyc), 32'd4);
    check_result(0, two, "bp new op");
    @(posedge clk);
    @(negedge clk);
    check("bp new op handshake", 32'(ov_w[0]), 32'd0);

    // Reset during the second RUN cycle.
    a_drv = 32'h1111_1111; b_drv = 32'h2222_2222; sub_drv = 1'b0; iv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid-run rst out_valid", 32'(ov_w[0]), 32'd0);
    check("mid-run rst S", s_w[0], 32'd0);
    check("mid-run rst Co", 32'(co_w[0]), 32'd0);
    check("mid-run rst in_ready during rst", 32'(rdy_w[0]), 32'd0);
    rst = 1'b0;
    #1;
    check("mid-run rst in_ready after release", 32'(rdy_w[0]), 32'd1);
    post = vecs[4];
    run_op(0, post, "post-reset op");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
